hw_stack: RTL and testbench
===========================

Name: hw_stack

Overview:
- LIFO stack that services the decoder's `pushEn`/`popEn` strobes (responder end of the stack interface).
- It returns `stackFull`/`stackEmpty` status and the top-of-stack word back to the datapath.
- Popped data feeds the register-write mux (mux1 select 3) or the PC mux (pcmux select 2) in the same e1 cycle.
- Pushed data comes from the register output mux or from PC+1 for call-style pushes.

Parameters:
- DATA_W, 16, width of each stack entry.
- DEPTH, 8, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  asynchronous active-low reset.
- push_en  input  1  push strobe, from decoder `pushEn` (psh & e1).
- pop_en  input  1  pop strobe, from decoder `popEn` (pop & e1).
- push_data  input  DATA_W  word to push.
- err_clr  input  1  synchronous clear of the sticky error flags.
- top_data  output  DATA_W  current top-of-stack word; combinational from state.
- stack_full  output  1  count == DEPTH.
- stack_empty  output  1  count == 0.
- count  output  PTR_W+1  number of valid entries.
- overflow  output  1  sticky; set by a push when full.
- underflow  output  1  sticky; set by a pop when empty.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (`reset_n`). All state updates on the rising edge of `clk`.
- Reset values: count=0, write pointer=0, stack_empty=1, stack_full=0, overflow=0, underflow=0, top_data=0. Storage array is not reset.
- top_data:
  - equals mem[wp-1 mod DEPTH] when count>0; forced to 0 when empty;
  - zero-latency read, so the decoder can load a register or PC at the end of the same e1 cycle in which pop_en is high;
  - the pre-edge value is the popped value.
- Push only (push_en=1, pop_en=0):
  - not full: mem[wp]<=push_data, wp<=wp+1 (wraps mod DEPTH), count+1;
  - full: see Optional Feature.
- Pop only:
  - not empty: wp<=wp-1, count-1; the entry is not cleared;
  - empty: no state change, underflow<=1.
- Push and pop in the same cycle:
  - not empty: replace top, mem[wp-1]<=push_data; wp and count unchanged; no flag change even if full;
  - empty: treated as push only; underflow is not set.
- stack_full and stack_empty are decoded from the registered count. They update the cycle after the causing edge; they are never registered separately.
- err_clr: clears overflow and underflow on the edge. If an error event occurs in the same cycle, the set wins.
- Reset asserted mid-operation: immediate return to reset values; any in-flight push is lost.
- count never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: HW_STACK_OVERWRITE_EN.
- Defined: push when full overwrites the oldest entry (circular buffer).
  - mem[wp]<=push_data, wp+1, count stays DEPTH, overflow<=1.
  - Successive pops return the newest DEPTH values.
  - Needs a bottom pointer, or derives bottom as wp-count.
- Undefined: push when full is dropped; no storage or pointer change; overflow<=1.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on three edges -> count=3, top_data=0x3333, stack_empty=0; pop once -> top_data=0x2222 before the next edge, count=2.
- DEPTH=8: push 8 values 0x0001..0x0008 -> stack_full=1 the cycle after the 8th push. Push 0x00FF:
  - without macro: overflow=1, top_data=0x0008, count=8;
  - with macro: overflow=1, top_data=0x00FF, and 8 pops return 0x00FF,0x0008..0x0002.
- Empty stack, pop_en=1 -> underflow=1, count=0, top_data=0. Assert err_clr -> underflow=0. err_clr and another empty pop in the same cycle -> underflow stays 1.
- count=2 with top 0xAAAA; push_en=pop_en=1, push_data=0xBBBB -> count=2, top_data=0xBBBB. On an empty stack the same stimulus gives count=1, top_data=0xBBBB, underflow=0.
- Push 3 entries, drop reset_n low mid-cycle (asynchronous, not on an edge) -> count=0, stack_empty=1, top_data=0, flags=0 immediately; after release a pop sets underflow.
- Wrap check: 100 random push/pop mixes against a reference model queue -> top_data, count and flags match every cycle.

Source files
------------

// File: rtl/hw_stack.sv
// LIFO stack with zero-latency top-of-stack read and sticky overflow/underflow flags.
// Define HW_STACK_OVERWRITE_EN to let a push into a full stack overwrite the oldest entry.
module hw_stack #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_en,
    input  logic              pop_en,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top_data,
    output logic              stack_full,
    output logic              stack_empty,
    output logic [PTR_W:0]    count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              we_s;
    logic [PTR_W-1:0]  waddr_s;
    logic              full_s, empty_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == {(PTR_W+1){1'b0}});

    // Next-state decode for pointer, count, sticky flags and the storage write port.
    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        we_s    = 1'b0;
        waddr_s = wp_q;
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
            udf_d = udf_q;
        end
        case ({push_en, pop_en})
            2'b10: begin
                if (!full_s) begin
                    we_s    = 1'b1;
                    wp_d    = wp_q + PTR_ONE;
                    count_d = count_q + CNT_ONE;
                end else begin
                    ovf_d = 1'b1;
`ifdef HW_STACK_OVERWRITE_EN
                    // Circular overwrite: the oldest slot is exactly the one at wp.
                    we_s = 1'b1;
                    wp_d = wp_q + PTR_ONE;
`endif
                end
            end
            2'b01: begin
                if (!empty_s) begin
                    wp_d    = wp_q - PTR_ONE;
                    count_d = count_q - CNT_ONE;
                end else begin
                    udf_d = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_s) begin
                    we_s    = 1'b1;
                    waddr_s = wp_q - PTR_ONE;
                end else begin
                    we_s    = 1'b1;
                    wp_d    = wp_q + PTR_ONE;
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= {PTR_W{1'b0}};
            count_q <= {(PTR_W+1){1'b0}};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[waddr_s] <= push_data;
        end
    end

    assign top_data    = empty_s ? {DATA_W{1'b0}} : mem_q[wp_q - PTR_ONE];
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = udf_q;

endmodule

// File: tb/tb_hw_stack.sv
// Directed and randomized self-checking bench for hw_stack (honours HW_STACK_OVERWRITE_EN).
module tb_hw_stack;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              reset_n;
    logic              push_en;
    logic              pop_en;
    logic [DATA_W-1:0] push_data;
    logic              err_clr;
    logic [DATA_W-1:0] top_data;
    logic              stack_full;
    logic              stack_empty;
    logic [3:0]        count;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    hw_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_en    (push_en),
        .pop_en     (pop_en),
        .push_data  (push_data),
        .err_clr    (err_clr),
        .top_data   (top_data),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] v);
        push_en = 1'b1; pop_en = 1'b0; push_data = v;
        step();
        push_en = 1'b0;
    endtask

    task automatic pop();
        push_en = 1'b0; pop_en = 1'b1;
        step();
        pop_en = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [DATA_W-1:0] t, input int c,
                              input logic f, input logic e, input logic o, input logic u);
        chk({tag, ".top"},   32'(top_data),    32'(t));
        chk({tag, ".count"}, 32'(count),       32'(c));
        chk({tag, ".full"},  32'(stack_full),  32'(f));
        chk({tag, ".empty"}, 32'(stack_empty), 32'(e));
        chk({tag, ".ovf"},   32'(overflow),    32'(o));
        chk({tag, ".udf"},   32'(underflow),   32'(u));
    endtask

    logic [DATA_W-1:0] mq[$];
    logic              m_ovf, m_udf;

    initial begin
        reset_n = 1'b0; push_en = 1'b0; pop_en = 1'b0; push_data = '0; err_clr = 1'b0;
        #2;
        chk_status("reset", 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        #10 reset_n = 1'b1;

        // Basic push/pop.
        push(16'h1111); push(16'h2222); push(16'h3333);
        chk_status("push3", 16'h3333, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        pop_en = 1'b1;
        #1 chk("pop_pre_edge.top", 32'(top_data), 32'h3333);
        step(); pop_en = 1'b0;
        chk_status("pop1", 16'h2222, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back to empty via asynchronous reset pulse.
        #3 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        for (int i = 1; i <= 8; i++) push(16'(i));
        chk_status("fill8", 16'h0008, 8, 1'b1, 1'b0, 1'b0, 1'b0);
        push(16'h00FF);
`ifdef HW_STACK_OVERWRITE_EN
        chk_status("push_full", 16'h00FF, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d.top", i), 32'(top_data), (i == 0) ? 32'h00FF : 32'(9 - i));
            pop();
        end
`else
        chk_status("push_full", 16'h0008, 8, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d.top", i), 32'(top_data), 32'(8 - i));
            pop();
        end
`endif
        chk_status("drained", 16'h0000, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Underflow and error clear.
        pop();
        chk_status("udf", 16'h0000, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk_status("clr", 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        err_clr = 1'b1; pop(); err_clr = 1'b0;
        chk_status("clr_vs_pop", 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("clr2.udf", 32'(underflow), 32'h0);

        // Simultaneous push and pop.
        push(16'h1234); push(16'hAAAA);
        push_en = 1'b1; pop_en = 1'b1; push_data = 16'hBBBB;
        step(); push_en = 1'b0; pop_en = 1'b0;
        chk_status("replace", 16'hBBBB, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        pop();
        chk_status("replace_below", 16'h1234, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        pop();
        push_en = 1'b1; pop_en = 1'b1; push_data = 16'hBBBB;
        step(); push_en = 1'b0; pop_en = 1'b0;
        chk_status("both_empty", 16'hBBBB, 1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle.
        push(16'h0011); push(16'h0022);
        chk("pre_rst.count", 32'(count), 32'd3);
        push_en = 1'b1; push_data = 16'h0033;
        #3 reset_n = 1'b0;
        #1 chk_status("async_rst", 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_en = 1'b0;
        step();
        chk_status("rst_hold", 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        #3 reset_n = 1'b1;
        pop();
        chk_status("post_rst_pop", 16'h0000, 0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Randomized mix against a reference queue.
        m_ovf = 1'b0; m_udf = 1'b1;
        for (int n = 0; n < 100; n++) begin
            push_en   = ($urandom_range(0, 9) < 6);
            pop_en    = ($urandom_range(0, 9) < 4);
            err_clr   = ($urandom_range(0, 15) == 0);
            push_data = 16'($urandom);
            if (err_clr) begin
                m_ovf = 1'b0; m_udf = 1'b0;
            end
            if (push_en && !pop_en) begin
                if (mq.size() < DEPTH) mq.push_back(push_data);
                else begin
                    m_ovf = 1'b1;
`ifdef HW_STACK_OVERWRITE_EN
                    void'(mq.pop_front());
                    mq.push_back(push_data);
`endif
                end
            end else if (!push_en && pop_en) begin
                if (mq.size() > 0) void'(mq.pop_back());
                else m_udf = 1'b1;
            end else if (push_en && pop_en) begin
                if (mq.size() > 0) mq[mq.size()-1] = push_data;
                else mq.push_back(push_data);
            end
            step();
            chk_status($sformatf("rnd%0d", n), (mq.size() > 0) ? mq[mq.size()-1] : 16'h0000,
                       mq.size(), mq.size() == DEPTH, mq.size() == 0, m_ovf, m_udf);
        end
        push_en = 1'b0; pop_en = 1'b0; err_clr = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
